// File: rtl/sv_dma_pkg.sv
// Shared definitions for the DMA engine: FSM states, register offsets,
// ctrl/status bit positions and the transfer-length helper.
`timescale 1ns/1ps
package sv_dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARB  = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   // Per-channel register offsets (low 3 bits of cfg_addr)
   localparam logic [2:0] REG_SRC_LO = 3'd0;
   localparam logic [2:0] REG_SRC_HI = 3'd1;
   localparam logic [2:0] REG_DST_LO = 3'd2;
   localparam logic [2:0] REG_DST_HI = 3'd3;
   localparam logic [2:0] REG_LEN    = 3'd4;
   localparam logic [2:0] REG_CTRL   = 3'd5;
   localparam logic [2:0] REG_FILL   = 3'd6;
   localparam logic [2:0] REG_STATUS = 3'd7;

   // ctrl register bits
   localparam int unsigned CTRL_START  = 7;
   localparam int unsigned CTRL_ABORT  = 6;
   localparam int unsigned CTRL_FILL   = 1;
   localparam int unsigned CTRL_IRQ_EN = 0;

   // status register bits
   localparam int unsigned STAT_ACTIVE  = 7;
   localparam int unsigned STAT_PENDING = 6;
   localparam int unsigned STAT_DONE    = 0;

   // Bytes moved for a len value; len=0 encodes 256 units.
   function automatic int unsigned xfer_bytes(logic [7:0] len, int unsigned unit);
      int unsigned units;
      units = (len == 8'd0) ? 32'd256 : 32'(len);
      return units * unit;
   endfunction

endpackage

// File: rtl/sv_dma_rr_arb.sv
// Round-robin arbiter: searches the request vector starting at the entry
// after last_i and returns the first requester found.
//   req_i      : request (pending) vector
//   last_i     : index granted most recently
//   gnt_c_o    : granted index (combinational)
//   valid_c_o  : a request was found (combinational)
`timescale 1ns/1ps
module sv_dma_rr_arb
   import sv_dma_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [IDX_W-1:0] gnt_c_o,
   output logic             valid_c_o
);

   // Scan N entries, wrapping, beginning one past the last grant
   always_comb begin
      gnt_c_o   = '0;
      valid_c_o = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned idx;
         idx = (32'(last_i) + k) % N;
         if (!valid_c_o && req_i[IDX_W'(idx)]) begin
            gnt_c_o   = IDX_W'(idx);
            valid_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sv_dma_engine.sv
// Multi-channel byte DMA engine with memory-to-memory copy and fill modes.
//   clk, reset_n        : clock, async active-low reset
//   cfg_we/addr/din     : CPU register write port; cfg_addr = {channel, reg}
//   cfg_dout            : combinational register read data
//   bus_addr/dout/din   : bus master address / write data / read data
//   bus_re, bus_we      : single-cycle strobes, gated by rdy
//   rdy                 : bus grant; low freezes the engine
//   busy                : engine owns the bus (state != IDLE)
//   irq                 : per-channel done & irq_en
`timescale 1ns/1ps
module sv_dma_engine
   import sv_dma_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned UNIT     = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        cfg_we,
   input  logic [$clog2(CHANNELS)+2:0] cfg_addr,
   input  logic [7:0]                  cfg_din,
   output logic [7:0]                  cfg_dout,
   output logic [ADDR_W-1:0]           bus_addr,
   output logic [7:0]                  bus_dout,
   input  logic [7:0]                  bus_din,
   output logic                        bus_re,
   output logic                        bus_we,
   input  logic                        rdy,
   output logic                        busy,
   output logic [CHANNELS-1:0]         irq
);

   localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned CNT_W = $clog2(UNIT) + 9;

   // CPU-visible per-channel registers
   logic [CHANNELS-1:0][7:0] src_lo_q, src_lo_d, src_hi_q, src_hi_d;
   logic [CHANNELS-1:0][7:0] dst_lo_q, dst_lo_d, dst_hi_q, dst_hi_d;
   logic [CHANNELS-1:0][7:0] len_q, len_d, fill_q, fill_d;
   logic [CHANNELS-1:0]      irq_en_q, irq_en_d, fill_mode_q, fill_mode_d;
   logic [CHANNELS-1:0]      active_q, active_d, pending_q, pending_d;
   logic [CHANNELS-1:0]      done_q, done_d;

   // Working state of the transfer in flight
   state_e              state_q, state_d;
   logic [CH_W-1:0]     cur_q, cur_d, last_q, last_d;
   logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          data_q, data_d;
   logic                mode_q, mode_d;
   logic                abort_q, abort_d;

   logic [CH_W-1:0]     cfg_ch;
   logic [2:0]          cfg_reg;
   logic                cfg_ok, cfg_locked, abort_wr, abort_now;
   logic [CH_W-1:0]     gnt;
   logic                gnt_valid;

   assign cfg_ch     = CH_W'(cfg_addr >> 3);
   assign cfg_reg    = cfg_addr[2:0];
   assign cfg_ok     = (32'(cfg_ch) < CHANNELS);
   assign cfg_locked = active_q[cfg_ch] | pending_q[cfg_ch];
   assign abort_wr   = cfg_we & cfg_ok & (cfg_reg == REG_CTRL) & cfg_din[CTRL_ABORT];
   assign abort_now  = abort_wr & active_q[cfg_ch];

   sv_dma_rr_arb #(
      .N     (CHANNELS),
      .IDX_W (CH_W)
   ) u_arb (
      .req_i     (pending_q),
      .last_i    (last_q),
      .gnt_c_o   (gnt),
      .valid_c_o (gnt_valid)
   );

   // Register read mux
   always_comb begin
      cfg_dout = 8'h00;
      if (cfg_ok) begin
         case (cfg_reg)
            REG_SRC_LO: cfg_dout = src_lo_q[cfg_ch];
            REG_SRC_HI: cfg_dout = src_hi_q[cfg_ch];
            REG_DST_LO: cfg_dout = dst_lo_q[cfg_ch];
            REG_DST_HI: cfg_dout = dst_hi_q[cfg_ch];
            REG_LEN:    cfg_dout = len_q[cfg_ch];
            REG_CTRL: begin
               cfg_dout[CTRL_FILL]   = fill_mode_q[cfg_ch];
               cfg_dout[CTRL_IRQ_EN] = irq_en_q[cfg_ch];
            end
            REG_FILL:   cfg_dout = fill_q[cfg_ch];
            REG_STATUS: begin
               cfg_dout[STAT_ACTIVE]  = active_q[cfg_ch];
               cfg_dout[STAT_PENDING] = pending_q[cfg_ch];
               cfg_dout[STAT_DONE]    = done_q[cfg_ch];
            end
            default: cfg_dout = 8'h00;
         endcase
      end
   end

   // Next state: CPU writes first, then the FSM, so a done set beats a clear
   always_comb begin
      src_lo_d    = src_lo_q;
      src_hi_d    = src_hi_q;
      dst_lo_d    = dst_lo_q;
      dst_hi_d    = dst_hi_q;
      len_d       = len_q;
      fill_d      = fill_q;
      irq_en_d    = irq_en_q;
      fill_mode_d = fill_mode_q;
      active_d    = active_q;
      pending_d   = pending_q;
      done_d      = done_q;
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      src_d       = src_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      mode_d      = mode_q;
      abort_d     = abort_q;

      if (cfg_we && cfg_ok) begin
         case (cfg_reg)
            REG_SRC_LO: if (!cfg_locked) src_lo_d[cfg_ch] = cfg_din;
            REG_SRC_HI: if (!cfg_locked) src_hi_d[cfg_ch] = cfg_din;
            REG_DST_LO: if (!cfg_locked) dst_lo_d[cfg_ch] = cfg_din;
            REG_DST_HI: if (!cfg_locked) dst_hi_d[cfg_ch] = cfg_din;
            REG_LEN:    if (!cfg_locked) len_d[cfg_ch]    = cfg_din;
            REG_FILL:   if (!cfg_locked) fill_d[cfg_ch]   = cfg_din;
            REG_CTRL: begin
               irq_en_d[cfg_ch]    = cfg_din[CTRL_IRQ_EN];
               fill_mode_d[cfg_ch] = cfg_din[CTRL_FILL];
               // Abort takes precedence over a simultaneous start
               if (cfg_din[CTRL_ABORT]) begin
                  pending_d[cfg_ch] = 1'b0;
                  if (active_q[cfg_ch]) abort_d = 1'b1;
               end else if (cfg_din[CTRL_START]) begin
                  pending_d[cfg_ch] = 1'b1;
               end
            end
            REG_STATUS: if (cfg_din[STAT_DONE]) done_d[cfg_ch] = 1'b0;
            default: ;
         endcase
      end

      // rdy low freezes every state, including IDLE and ARB
      if (rdy) begin
         case (state_q)
            ST_IDLE: if (|pending_q) state_d = ST_ARB;
            ST_ARB: begin
               if (gnt_valid) begin
                  cur_d           = gnt;
                  last_d          = gnt;
                  src_d           = ADDR_W'({src_hi_q[gnt], src_lo_q[gnt]});
                  dst_d           = ADDR_W'({dst_hi_q[gnt], dst_lo_q[gnt]});
                  cnt_d           = CNT_W'(xfer_bytes(len_q[gnt], UNIT));
                  mode_d          = fill_mode_q[gnt];
                  pending_d[gnt]  = 1'b0;
                  active_d[gnt]   = 1'b1;
                  // An abort landing on the channel just granted still counts
                  abort_d         = abort_wr & (cfg_ch == gnt);
                  state_d         = fill_mode_q[gnt] ? ST_WR : ST_RD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RD:  state_d = ST_CAP;
            ST_CAP: begin
               data_d  = bus_din;
               state_d = ST_WR;
            end
            ST_WR: begin
               cnt_d = cnt_q - CNT_W'(1);
               src_d = src_q + ADDR_W'(1);
               dst_d = dst_q + ADDR_W'(1);
               if (cnt_q == CNT_W'(1) || abort_q || abort_now) state_d = ST_DONE;
               else                                           state_d = mode_q ? ST_WR : ST_RD;
            end
            ST_DONE: begin
               active_d[cur_q] = 1'b0;
               if (!abort_q) done_d[cur_q] = 1'b1;
               abort_d = 1'b0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers; last_q starts at the top channel so channel 0 wins first
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_lo_q    <= '0;
         src_hi_q    <= '0;
         dst_lo_q    <= '0;
         dst_hi_q    <= '0;
         len_q       <= '0;
         fill_q      <= '0;
         irq_en_q    <= '0;
         fill_mode_q <= '0;
         active_q    <= '0;
         pending_q   <= '0;
         done_q      <= '0;
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         last_q      <= CH_W'(CHANNELS - 1);
         src_q       <= '0;
         dst_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         mode_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         src_lo_q    <= src_lo_d;
         src_hi_q    <= src_hi_d;
         dst_lo_q    <= dst_lo_d;
         dst_hi_q    <= dst_hi_d;
         len_q       <= len_d;
         fill_q      <= fill_d;
         irq_en_q    <= irq_en_d;
         fill_mode_q <= fill_mode_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         done_q      <= done_d;
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         mode_q      <= mode_d;
         abort_q     <= abort_d;
      end
   end

   // Strobes follow rdy in the same cycle so nothing fires during a stall
   assign busy     = (state_q != ST_IDLE);
   assign bus_re   = (state_q == ST_RD) & rdy;
   assign bus_we   = (state_q == ST_WR) & rdy;
   assign bus_addr = (state_q == ST_RD) ? src_q :
                     (state_q == ST_WR) ? dst_q : '0;
   assign bus_dout = (state_q != ST_WR) ? 8'h00 :
                     (mode_q ? fill_q[cur_q] : data_q);
   assign irq      = done_q & irq_en_q;

endmodule

// File: doc/sv_dma_engine.md
SV_DMA_ENGINE -- requirements
Module: sv_dma_engine

Interface
REQ-001 CHANNELS, default 2: number of independent DMA channels, 1..4.
REQ-002 ADDR_W, default 16: bus address width.
REQ-003 UNIT, default 16: bytes per length count; power of two.
REQ-004 clk  in  1: single clock for all logic.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 cfg_we  in  1: register write strobe.
REQ-007 cfg_addr  in  $clog2(CHANNELS)+3: upper bits select the channel, low 3 bits select the register.
REQ-008 cfg_din  in  8 / cfg_dout  out  8: register write data / combinational register read data.
REQ-009 bus_addr  out  ADDR_W / bus_dout  out  8 / bus_din  in  8: master address, write data, read data; read data valid one cycle after bus_re.
REQ-010 bus_re  out  1 / bus_we  out  1: one-cycle read and write strobes.
REQ-011 rdy  in  1: bus grant; 0 stalls the engine.
REQ-012 busy  out  1: high while any transfer owns the bus; the CPU RDY input is driven from ~busy.
REQ-013 irq  out  CHANNELS: per-channel done interrupt (done AND irq_en).

Function
REQ-014 Per-channel registers: 0 src_lo, 1 src_hi, 2 dst_lo, 3 dst_hi, 4 len, 5 ctrl, 6 fill, 7 status.
REQ-015 ctrl bits: b7 start, b6 abort, b1 fill mode, b0 irq_en. Start and abort are self-clearing.
REQ-016 status read: b7 active, b6 pending, b0 done. A write with b0=1 clears done.
REQ-017 A write of start=1 sets pending. Writes to regs 0-4 and 6 of an active or pending channel are ignored.
REQ-018 Byte count = len*UNIT. len=0 means 256*UNIT.
REQ-019 Addresses increment by 1 per byte and wrap modulo 2^ADDR_W.
REQ-020 FSM states: IDLE, ARB, RD, CAP, WR, DONE.
REQ-021 IDLE->ARB when any channel is pending.
REQ-022 ARB: round-robin starting at the channel after the last one served. Load working src/dst/count. Clear pending, set active. Go to RD, or to WR when fill mode is set.
REQ-023 RD: assert bus_re with bus_addr=src, then go to CAP. CAP: latch bus_din, then go to WR.
REQ-024 WR: assert bus_we with bus_addr=dst and bus_dout=latched byte (fill byte in fill mode). Decrement count and increment src/dst. Go to DONE when count reaches 0, otherwise go to RD (or back to WR in fill mode).
REQ-025 DONE: clear active, set done, go to IDLE. The cycle count is 3 per byte for copy and 1 per byte for fill, plus 2 overhead cycles, when rdy=1.
REQ-026 rdy=0: the FSM holds its state and registers; bus_re and bus_we are 0. A byte captured in CAP is never lost.
REQ-027 busy = (state != IDLE).
REQ-028 abort on the active channel: the transfer stops after the current WR completes, goes through DONE without setting done. abort on a pending channel clears pending. abort on an idle channel does nothing.
REQ-029 If a done clear and a done set occur in the same cycle, the set wins.
REQ-030 A start issued on another channel during a transfer is queued as pending and served after the current transfer finishes.

Reset
REQ-031 All registers reset to 0. State resets to IDLE. busy, bus_re, bus_we, irq and bus_addr all reset to 0.
REQ-032 Reset asserted mid-transfer abandons the transfer immediately. No strobe is asserted in the cycle after reset is released.

Structure
REQ-033 Shared package sv_dma_pkg holds: the FSM state enum, register offset constants, and ctrl/status bit position constants.
REQ-034 One sub-module, sv_dma_rr_arb: parametrised round-robin arbiter taking a pending vector and last-grant, returning grant index and valid.

Verification
REQ-035 Ch0 src=0x4000, dst=0x0100, len=1, start, rdy=1 -> 16 bytes copied in order, busy high for 50 cycles, done=1, irq[0]=1 if irq_en.
REQ-036 Ch1 fill=0xA5, dst=0xFFF8, len=1, fill mode -> bytes 0xFFF8-0xFFFF then 0x0000-0x0007 written 0xA5, no bus_re.
REQ-037 Ch0 and ch1 started in the same cycle -> ch0 served first, then ch1. Repeated starts on both alternate the service order.
REQ-038 rdy toggled pseudo-randomly during a copy -> destination matches source and no strobe occurs while rdy=0.
REQ-039 Abort at byte 5 of a 16-byte copy -> exactly 5 or 6 bytes written, done=0, irq low, engine returns to IDLE.
REQ-040 reset_n pulsed low mid-copy -> all outputs 0 immediately and registers read back 0.
